// File: rtl/msf_encoder.sv
// MSF time-code modulator: slot/second counters, pending and frame
// registers, and a registered carrier on/off decode.
module msf_encoder #(
    parameter int CYCLES_PER_100MS = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] year_h_i,
    input  logic [3:0] year_l_i,
    input  logic       month_h_i,
    input  logic [3:0] month_l_i,
    input  logic [1:0] day_h_i,
    input  logic [3:0] day_l_i,
    input  logic [2:0] dow_i,
    input  logic [1:0] hour_h_i,
    input  logic [3:0] hour_l_i,
    input  logic [2:0] minute_h_i,
    input  logic [3:0] minute_l_i,
    input  logic       bst_i,
    output logic       data_o,
    output logic [5:0] second_o,
    output logic       frame_start_o
);

    localparam int CW = $clog2(CYCLES_PER_100MS);
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_100MS - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    slot_q, slot_d;
    logic [5:0]    sec_q, sec_d;
    logic [35:0]   pend_q, pend_d;
    logic [35:0]   frm_q, frm_d;
    logic          data_q, data_d;

    logic          cyc_wrap;
    logic          slot_wrap;
    logic          at_start;
    logic [35:0]   in_vec;
    logic [0:59]   a_bits;
    logic [0:59]   b_bits;
    logic          p_year, p_date, p_dow, p_time;

    assign in_vec = {year_h_i, year_l_i, month_h_i, month_l_i,
                     day_h_i, day_l_i, dow_i, hour_h_i, hour_l_i,
                     minute_h_i, minute_l_i, bst_i};

    assign cyc_wrap  = (cyc_q == CYC_LAST);
    assign slot_wrap = cyc_wrap && (slot_q == 4'd9);
    assign at_start  = (cyc_q == '0) && (slot_q == 4'd0) && (sec_q == 6'd0);

    always_comb begin
        cyc_d  = cyc_wrap ? '0 : cyc_q + 1'b1;
        slot_d = slot_q;
        sec_d  = sec_q;
        if (cyc_wrap) begin
            slot_d = (slot_q == 4'd9) ? 4'd0 : slot_q + 4'd1;
        end
        if (slot_wrap) begin
            sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        end
    end

    // A load coinciding with the frame copy feeds straight through pend_d.
    assign pend_d = load_i ? in_vec : pend_q;
    assign frm_d  = at_start ? pend_d : frm_q;

    assign a_bits = {17'd0, frm_q[35:1], 8'b0111_1110};

    assign p_year = ~^a_bits[17:24];
    assign p_date = ~^a_bits[25:35];
    assign p_dow  = ~^a_bits[36:38];
    assign p_time = ~^a_bits[39:51];

    assign b_bits = {54'd0, p_year, p_date, p_dow, p_time, frm_q[0], 1'b0};

    always_comb begin
        data_d = 1'b0;
        if (sec_q == 6'd0) begin
            data_d = (slot_q < 4'd5);
        end else begin
            case (slot_q)
                4'd0:    data_d = 1'b1;
                4'd1:    data_d = a_bits[sec_q];
                4'd2:    data_d = b_bits[sec_q];
                default: data_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q  <= '0;
            slot_q <= 4'd0;
            sec_q  <= 6'd0;
            pend_q <= '0;
            frm_q  <= '0;
            data_q <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
            sec_q  <= sec_d;
            pend_q <= pend_d;
            frm_q  <= frm_d;
            data_q <= data_d;
        end
    end

    assign data_o        = data_q;
    assign second_o      = sec_q;
    assign frame_start_o = at_start && !rst_i;

endmodule

// File: tb/tb_msf_encoder.sv
// Bench for msf_encoder: expected per-second carrier patterns are queued
// by the stimulus and matched by a monitor that reassembles each second.
module tb_msf_encoder;

    localparam int CPS     = 4;
    localparam int SEC_CYC = 10 * CPS;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       load_i;
    logic [3:0] year_h_i, year_l_i;
    logic       month_h_i;
    logic [3:0] month_l_i;
    logic [1:0] day_h_i;
    logic [3:0] day_l_i;
    logic [2:0] dow_i;
    logic [1:0] hour_h_i;
    logic [3:0] hour_l_i;
    logic [2:0] minute_h_i;
    logic [3:0] minute_l_i;
    logic       bst_i;
    logic       data_o;
    logic [5:0] second_o;
    logic       frame_start_o;

    msf_encoder #(.CYCLES_PER_100MS(CPS)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (load_i),
        .year_h_i     (year_h_i),
        .year_l_i     (year_l_i),
        .month_h_i    (month_h_i),
        .month_l_i    (month_l_i),
        .day_h_i      (day_h_i),
        .day_l_i      (day_l_i),
        .dow_i        (dow_i),
        .hour_h_i     (hour_h_i),
        .hour_l_i     (hour_l_i),
        .minute_h_i   (minute_h_i),
        .minute_l_i   (minute_l_i),
        .bst_i        (bst_i),
        .data_o       (data_o),
        .second_o     (second_o),
        .frame_start_o(frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int                  fno;
        int                  sec;
        logic [SEC_CYC-1:0]  pat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [SEC_CYC-1:0] mk_pat(input int s, input bit a, input bit b);
        logic [SEC_CYC-1:0] p;
        p = '0;
        for (int i = 0; i < SEC_CYC; i++) begin
            int sl;
            sl = i / CPS;
            if (s == 0) p[i] = (sl < 5);
            else        p[i] = (sl == 0) || (sl == 1 && a) || (sl == 2 && b);
        end
        return p;
    endfunction

    task automatic expect_sec(input int f, input int s, input bit a, input bit b);
        exp_t e;
        e.fno = f;
        e.sec = s;
        e.pat = mk_pat(s, a, b);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_rec(input int f, input int s, input logic [SEC_CYC-1:0] pat);
        exp_t e;
        while (sb.size() > 0 &&
               (sb[0].fno < f || (sb[0].fno == f && sb[0].sec < s))) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missed f%0d s%0d: never observed", e.fno, e.sec);
        end
        if (sb.size() > 0 && sb[0].fno == f && sb[0].sec == s) begin
            e = sb.pop_front();
            checks++;
            if (pat !== e.pat) begin
                errors++;
                $display("FAIL sb f%0d s%0d: got %b want %b", f, s, pat, e.pat);
            end
        end
    endtask

    // data_o in a cycle belongs to the counter state of the cycle before.
    int                 fno  = 0;
    int                 psec = 0;
    int                 pidx = 0;
    int                 pfno = 0;
    bit                 vld  = 1'b0;
    logic [SEC_CYC-1:0] cap  = '0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            vld = 1'b0;
        end else begin
            if (vld && pidx < SEC_CYC) begin
                cap[pidx] = data_o;
                if (pidx == SEC_CYC - 1) check_rec(pfno, psec, cap);
            end
            if (frame_start_o) fno++;
            if (!vld || int'(second_o) != psec) pidx = 0;
            else                                pidx = pidx + 1;
            psec = int'(second_o);
            pfno = fno;
            vld  = 1'b1;
        end
    end

    task automatic load_time(input int yr, input int mo, input int dy, input int dw,
                             input int hr, input int mi, input bit bst);
        year_h_i   = 4'(yr / 10);
        year_l_i   = 4'(yr % 10);
        month_h_i  = 1'(mo / 10);
        month_l_i  = 4'(mo % 10);
        day_h_i    = 2'(dy / 10);
        day_l_i    = 4'(dy % 10);
        dow_i      = 3'(dw);
        hour_h_i   = 2'(hr / 10);
        hour_l_i   = 4'(hr % 10);
        minute_h_i = 3'(mi / 10);
        minute_l_i = 4'(mi % 10);
        bst_i      = bst;
        load_i     = 1'b1;
        @(posedge clk_i); #1;
        load_i     = 1'b0;
    endtask

    task automatic wait_sec(input int s);
        int n;
        n = 0;
        while (int'(second_o) != s && n < 3000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (int'(second_o) != s) begin
            checks++;
            errors++;
            $display("FAIL wait_sec: got second %0d want %0d", second_o, s);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!frame_start_o && n < 3000);
        if (!frame_start_o) begin
            checks++;
            errors++;
            $display("FAIL wait_fs: got no frame start want pulse");
        end
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk({tag, " data_o"}, int'(data_o), 0);
            chk({tag, " second_o"}, int'(second_o), 0);
            chk({tag, " frame_start_o"}, int'(frame_start_o), 0);
        end
        rst_i = 1'b0;
        #1;
        chk({tag, " release frame_start_o"}, int'(frame_start_o), 1);
        chk({tag, " release second_o"}, int'(second_o), 0);
    endtask

    initial begin
        rst_i = 1'b1;
        load_i = 1'b0;
        year_h_i = '0; year_l_i = '0; month_h_i = '0; month_l_i = '0;
        day_h_i = '0; day_l_i = '0; dow_i = '0; hour_h_i = '0;
        hour_l_i = '0; minute_h_i = '0; minute_l_i = '0; bst_i = 1'b0;

        // frame 1: empty content
        expect_sec(1, 0, 0, 0);
        expect_sec(1, 1, 0, 0);
        expect_sec(1, 17, 0, 0);
        expect_sec(1, 52, 0, 0);
        expect_sec(1, 53, 1, 0);
        expect_sec(1, 54, 1, 1);
        expect_sec(1, 55, 1, 1);
        expect_sec(1, 56, 1, 1);
        expect_sec(1, 57, 1, 1);
        expect_sec(1, 58, 1, 0);
        expect_sec(1, 59, 0, 0);
        // frame 2: 99-12-31 dow 2 23:59 bst
        expect_sec(2, 0, 0, 0);
        expect_sec(2, 17, 1, 0);
        expect_sec(2, 18, 0, 0);
        expect_sec(2, 25, 1, 0);
        expect_sec(2, 30, 1, 0);
        expect_sec(2, 37, 1, 0);
        expect_sec(2, 39, 1, 0);
        expect_sec(2, 45, 1, 0);
        expect_sec(2, 46, 0, 0);
        expect_sec(2, 54, 1, 1);
        expect_sec(2, 55, 1, 0);
        expect_sec(2, 56, 1, 0);
        expect_sec(2, 57, 1, 0);
        expect_sec(2, 58, 1, 1);
        expect_sec(2, 59, 0, 0);
        // frame 3: 25-06-15 dow 5 08:30
        expect_sec(3, 0, 0, 0);
        expect_sec(3, 17, 0, 0);
        expect_sec(3, 19, 1, 0);
        expect_sec(3, 22, 1, 0);
        expect_sec(3, 24, 1, 0);
        expect_sec(3, 27, 1, 0);
        expect_sec(3, 36, 1, 0);
        expect_sec(3, 38, 1, 0);
        expect_sec(3, 39, 0, 0);
        expect_sec(3, 41, 1, 0);
        expect_sec(3, 46, 1, 0);
        expect_sec(3, 47, 1, 0);
        expect_sec(3, 54, 1, 0);
        expect_sec(3, 55, 1, 0);
        expect_sec(3, 56, 1, 1);
        expect_sec(3, 57, 1, 0);
        expect_sec(3, 58, 1, 0);
        // frame 4: 01-00-00 dow 0 00:00 loaded on the start cycle
        expect_sec(4, 0, 0, 0);
        expect_sec(4, 19, 0, 0);
        expect_sec(4, 22, 0, 0);
        expect_sec(4, 24, 1, 0);
        expect_sec(4, 36, 0, 0);
        expect_sec(4, 41, 0, 0);
        // frame 5: after mid-frame reset, zero content
        expect_sec(5, 0, 0, 0);
        expect_sec(5, 24, 0, 0);
        expect_sec(5, 53, 1, 0);
        expect_sec(5, 54, 1, 1);
        expect_sec(5, 57, 1, 1);
        expect_sec(5, 58, 1, 0);

        @(posedge clk_i); #1;
        do_reset("rst0");

        wait_sec(10);
        load_time(99, 12, 31, 2, 23, 59, 1'b1);

        wait_fs();
        wait_sec(30);
        load_time(25, 6, 15, 5, 8, 30, 1'b0);

        wait_fs();
        wait_sec(5);
        wait_fs();
        load_time(1, 0, 0, 0, 0, 0, 1'b1);

        wait_sec(45);
        do_reset("rst45");

        wait_sec(59);
        repeat (50) @(posedge clk_i);
        #1;

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL leftover f%0d s%0d: never observed", e.fno, e.sec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
